// File: rtl/coin_payer.sv
// Coin payer: inserts coins from a latched inventory until PRICE is reached,
// spacing pulses by GAP cycles, then waits for the seller's vend/change reply.
module coin_payer #(
  parameter int PRICE   = 3,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] n05,
  input  logic [2:0] n10,
  input  logic [2:0] n20,
  input  logic       vend,
  input  logic [1:0] change,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] paid,
  output logic [1:0] change_got,
  output logic       chg_err
);

  typedef enum logic [2:0] {S_IDLE, S_PAY, S_GAP, S_WAITV, S_DONE} state_t;
  typedef enum logic [1:0] {C_NONE, C_05, C_10, C_20} coin_t;

  state_t      state_q;
  coin_t       coin_d;
  logic [2:0]  c05_q, c10_q, c20_q;
  logic [15:0] gap_q, tmo_q;
  logic [3:0]  paid_q, coin_val_d, paid_d;
  logic [4:0]  sum_d;
  logic [1:0]  chg_q;
  logic        err_q, chg_err_d, full_d;
  logic        d1_q, d2_q, d3_q, busy_q, done_q, fail_q;

  always_comb begin
    coin_d = C_NONE;
    if ((int'(paid_q) + 2 <= PRICE) && (c10_q != '0)) coin_d = C_10;
    else if (c05_q != '0)                             coin_d = C_05;
    else if (c10_q != '0)                             coin_d = C_10;
    else if (c20_q != '0)                             coin_d = C_20;

    case (coin_d)
      C_05:    coin_val_d = 4'd1;
      C_10:    coin_val_d = 4'd2;
      C_20:    coin_val_d = 4'd4;
      default: coin_val_d = '0;
    endcase

    // Saturate rather than wrap so paid never misreports an overpayment.
    sum_d     = {1'b0, paid_q} + {1'b0, coin_val_d};
    paid_d    = sum_d[4] ? '1 : sum_d[3:0];
    full_d    = int'(paid_q) >= PRICE;
    chg_err_d = !full_d || ((int'(paid_q) - PRICE) != int'(change));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      c05_q   <= '0;
      c10_q   <= '0;
      c20_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      paid_q  <= '0;
      chg_q   <= '0;
      err_q   <= 1'b0;
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
      d3_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      d1_q   <= 1'b0;
      d2_q   <= 1'b0;
      d3_q   <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            c05_q   <= n05;
            c10_q   <= n10;
            c20_q   <= n20;
            paid_q  <= '0;
            chg_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_PAY;
          end
        end
        S_PAY: begin
          if (coin_d == C_NONE) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            unique case (coin_d)
              C_05: begin d1_q <= 1'b1; c05_q <= c05_q - 3'd1; end
              C_10: begin d2_q <= 1'b1; c10_q <= c10_q - 3'd1; end
              C_20: begin d3_q <= 1'b1; c20_q <= c20_q - 3'd1; end
              default: ;
            endcase
            paid_q  <= paid_d;
            gap_q   <= 16'(GAP);
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (vend) begin
            chg_q   <= change;
            err_q   <= chg_err_d;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (gap_q <= 16'd1) begin
            if (full_d) begin
              tmo_q   <= 16'(TIMEOUT);
              state_q <= S_WAITV;
            end else begin
              state_q <= S_PAY;
            end
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        S_WAITV: begin
          if (vend) begin
            chg_q   <= change;
            err_q   <= chg_err_d;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (tmo_q <= 16'd1) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q - 16'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign d1         = d1_q;
  assign d2         = d2_q;
  assign d3         = d3_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign paid       = paid_q;
  assign change_got = chg_q;
  assign chg_err    = err_q;

endmodule

// File: tb/tb_coin_payer.sv
// Bench for coin_payer: directed and random purchases checked against a
// cycle-timeline model of coin selection, gap spacing, vend and timeout.
module tb_coin_payer;
  localparam int PRICE   = 3;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       vend = 1'b0;
  logic [2:0] n05 = '0, n10 = '0, n20 = '0;
  logic [1:0] change = '0;
  logic       d1, d2, d3, busy, done, fail, chg_err;
  logic [3:0] paid;
  logic [1:0] change_got;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  coin_payer #(.PRICE(PRICE), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .n05(n05), .n10(n10), .n20(n20),
    .vend(vend), .change(change), .d1(d1), .d2(d2), .d3(d3), .busy(busy),
    .done(done), .fail(fail), .paid(paid), .change_got(change_got), .chg_err(chg_err)
  );

  int exp_pc[$], exp_pk[$];
  int exp_done, exp_fail, exp_paid, exp_chg, exp_err;
  int obs_pc[$], obs_pk[$];
  int obs_done, obs_fail, obs_busy_done, obs_paid, obs_chg, obs_err;
  int multi_bad, busy_bad, late_done;

  // Cycle 0 is the first cycle after start is sampled; pulses/done are
  // indexed by the cycle in which they are visible.
  task automatic model(input int a, input int b, input int c, input int v, input int chg);
    int p, t, dn, k;
    int pay_q[$];
    bit eff;
    p = 0; t = 0; dn = 0;
    exp_pc.delete(); exp_pk.delete();
    exp_fail = 1;
    forever begin
      if (p >= PRICE) begin dn = t + TIMEOUT; break; end
      pay_q.push_back(t);
      k = 0;
      if (PRICE - p >= 2 && b > 0) k = 2;
      else if (a > 0) k = 1;
      else if (b > 0) k = 2;
      else if (c > 0) k = 3;
      if (k == 0) begin dn = t + 1; break; end
      if (k == 1) a--; else if (k == 2) b--; else c--;
      p += (k == 1) ? 1 : (k == 2) ? 2 : 4;
      exp_pc.push_back(t + 1);
      exp_pk.push_back(k);
      t = t + 1 + GAP;
    end
    eff = (v >= 1) && (v < dn);
    foreach (pay_q[i]) if (pay_q[i] == v) eff = 0;
    if (eff) begin
      while (exp_pc.size() > 0 && exp_pc[exp_pc.size()-1] > v) begin
        void'(exp_pc.pop_back());
        void'(exp_pk.pop_back());
      end
      p = 0;
      foreach (exp_pk[i]) p += (exp_pk[i] == 1) ? 1 : (exp_pk[i] == 2) ? 2 : 4;
      exp_done = v + 1; exp_fail = 0; exp_paid = p; exp_chg = chg;
      exp_err = (p < PRICE || p - PRICE != chg) ? 1 : 0;
    end else begin
      exp_done = dn; exp_paid = p; exp_chg = 0; exp_err = 0;
    end
  endtask

  task automatic capture(input int a, input int b, input int c, input int v,
                         input int chg, input bit noisy);
    obs_pc.delete(); obs_pk.delete();
    obs_done = -1; obs_fail = -1; obs_busy_done = -1;
    obs_paid = -1; obs_chg = -1; obs_err = -1;
    multi_bad = 0; busy_bad = 0; late_done = 0;
    @(negedge clk);
    n05 = 3'(a); n10 = 3'(b); n20 = 3'(c); start = 1'b1; vend = 1'b0;
    @(posedge clk); #1;
    for (int cy = 0; cy < 200; cy++) begin
      if (d1 || d2 || d3) begin
        obs_pc.push_back(cy);
        obs_pk.push_back(d1 ? 1 : d2 ? 2 : 3);
        if (int'(d1) + int'(d2) + int'(d3) > 1) multi_bad++;
      end
      if (obs_done >= 0 && cy == obs_done + 1) begin
        late_done = int'(done);
        break;
      end
      if (done && obs_done < 0) begin
        obs_done = cy; obs_fail = int'(fail); obs_busy_done = int'(busy);
        obs_paid = int'(paid); obs_chg = int'(change_got); obs_err = int'(chg_err);
      end else if (obs_done < 0 && !busy) begin
        busy_bad++;
      end
      @(negedge clk);
      start  = noisy && ($urandom_range(0, 1) == 1);
      vend   = (cy == v);
      change = (cy == v) ? 2'(chg) : 2'($urandom_range(0, 3));
      if (noisy) begin
        n05 = 3'($urandom_range(0, 7)); n10 = 3'($urandom_range(0, 7)); n20 = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
    end
    start = 1'b0; vend = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; n05 = 3'd2; n10 = 3'd2; n20 = 3'd2; vend = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({d1, d2, d3, busy, done, fail, chg_err} !== 7'b0)
      begin bad++; $display("FAIL reset_flags got=%b want=0000000", {d1, d2, d3, busy, done, fail, chg_err}); end
    total++;
    if (paid !== 4'd0) begin bad++; $display("FAIL reset_paid got=%0d want=0", paid); end
    total++;
    if (change_got !== 2'd0) begin bad++; $display("FAIL reset_change got=%0d want=0", change_got); end
    @(negedge clk);
    rst = 1'b1; start = 1'b0; vend = 1'b0;
  endtask

  task automatic test_basic;
    capture(1, 1, 0, 6, 0, 1'b0);
    total++;
    if (obs_pc.size() !== 2) begin bad++; $display("FAIL basic_npulse got=%0d want=2", obs_pc.size()); end
    else begin
      total++;
      if (obs_pc[0] !== 1 || obs_pk[0] !== 2)
        begin bad++; $display("FAIL basic_pulse0 got=c%0d/d%0d want=c1/d2", obs_pc[0], obs_pk[0]); end
      total++;
      if (obs_pc[1] !== 4 || obs_pk[1] !== 1)
        begin bad++; $display("FAIL basic_pulse1 got=c%0d/d%0d want=c4/d1", obs_pc[1], obs_pk[1]); end
    end
    total++;
    if (obs_done !== 7) begin bad++; $display("FAIL basic_done got=%0d want=7", obs_done); end
    total++;
    if ({obs_fail, obs_paid, obs_chg, obs_err} !== {0, 3, 0, 0})
      begin bad++; $display("FAIL basic_result got=f%0d p%0d c%0d e%0d want=f0 p3 c0 e0", obs_fail, obs_paid, obs_chg, obs_err); end
  endtask

  task automatic test_purchases;
    int tab[6][5] = '{'{1, 1, 0, 6, 0}, '{0, 0, 1, 3, 1}, '{1, 0, 1, 7, 2},
                      '{1, 0, 1, 7, 1}, '{0, 0, 0, -1, 0}, '{3, 0, 0, -1, 0}};
    int a, b, c, v, chg, np;
    bit noisy;
    for (int n = 0; n < 46; n++) begin
      if (n < 6) begin
        a = tab[n][0]; b = tab[n][1]; c = tab[n][2]; v = tab[n][3]; chg = tab[n][4]; noisy = 0;
      end else begin
        a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
        chg = $urandom_range(0, 3); noisy = 1;
        model(a, b, c, -1, 0);
        v = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, exp_done + 1);
      end
      model(a, b, c, v, chg);
      capture(a, b, c, v, chg, noisy);
      total++;
      if (obs_done !== exp_done) begin bad++; $display("FAIL txn%0d done_cycle got=%0d want=%0d", n, obs_done, exp_done); end
      total++;
      if (obs_fail !== exp_fail) begin bad++; $display("FAIL txn%0d fail got=%0d want=%0d", n, obs_fail, exp_fail); end
      total++;
      if (obs_paid !== exp_paid) begin bad++; $display("FAIL txn%0d paid got=%0d want=%0d", n, obs_paid, exp_paid); end
      total++;
      if (obs_chg !== exp_chg) begin bad++; $display("FAIL txn%0d change_got got=%0d want=%0d", n, obs_chg, exp_chg); end
      total++;
      if (obs_err !== exp_err) begin bad++; $display("FAIL txn%0d chg_err got=%0d want=%0d", n, obs_err, exp_err); end
      total++;
      if (obs_pc.size() !== exp_pc.size())
        begin bad++; $display("FAIL txn%0d npulse got=%0d want=%0d", n, obs_pc.size(), exp_pc.size()); end
      np = (obs_pc.size() < exp_pc.size()) ? obs_pc.size() : exp_pc.size();
      for (int i = 0; i < np; i++) begin
        total++;
        if (obs_pc[i] !== exp_pc[i] || obs_pk[i] !== exp_pk[i])
          begin bad++; $display("FAIL txn%0d pulse%0d got=c%0d/d%0d want=c%0d/d%0d", n, i, obs_pc[i], obs_pk[i], exp_pc[i], exp_pk[i]); end
      end
      total++;
      if ({multi_bad, busy_bad, obs_busy_done, late_done} !== {0, 0, 0, 0})
        begin bad++; $display("FAIL txn%0d handshake got=m%0d b%0d bd%0d ld%0d want=all 0", n, multi_bad, busy_bad, obs_busy_done, late_done); end
    end
  endtask

  task automatic test_mid_reset;
    int pulses, dones;
    @(negedge clk);
    n05 = 3'd1; n10 = 3'd1; n20 = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (d2 !== 1'b1) begin bad++; $display("FAIL midrst_first_pulse got=%b want=1", d2); end
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (busy !== 1'b1 || paid !== 4'd2)
      begin bad++; $display("FAIL midrst_async got=busy%b paid%0d want=busy1 paid2", busy, paid); end
    @(posedge clk); #1;
    total++;
    if ({d1, d2, d3, busy, done, fail, chg_err, paid, change_got} !== 13'b0)
      begin bad++; $display("FAIL midrst_clear got=%b want=0", {d1, d2, d3, busy, done, fail, chg_err, paid, change_got}); end
    @(negedge clk); rst = 1'b1;
    pulses = 0; dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      pulses += int'(d1) + int'(d2) + int'(d3);
      dones  += int'(done) + int'(busy);
    end
    total++;
    if (pulses !== 0 || dones !== 0)
      begin bad++; $display("FAIL midrst_quiet got=pulses%0d done_busy%0d want=0/0", pulses, dones); end
  endtask

  task automatic test_back_to_back;
    int a_s[3] = '{1, 2, 0};
    int b_s[3] = '{1, 0, 0};
    int c_s[3] = '{0, 1, 0};
    int v_s[3] = '{6, -1, -1};
    for (int n = 0; n < 3; n++) begin
      model(a_s[n], b_s[n], c_s[n], v_s[n], 0);
      capture(a_s[n], b_s[n], c_s[n], v_s[n], 0, 1'b0);
      total++;
      if (obs_done !== exp_done || obs_fail !== exp_fail || obs_paid !== exp_paid || obs_pc.size() !== exp_pc.size())
        begin bad++; $display("FAIL b2b%0d got=d%0d f%0d p%0d n%0d want=d%0d f%0d p%0d n%0d", n,
          obs_done, obs_fail, obs_paid, obs_pc.size(), exp_done, exp_fail, exp_paid, exp_pc.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_purchases();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
